// File: rtl/lab_adder_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry,
// mode encodings and the carry-in adjustment used when subtracting.
package lab_adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Subtraction is a + ~b + ~borrow_in, so the carry entering bit 0 is
  // inverted in subtract mode and passed through in add mode.
  function automatic logic eff_carry_in(input logic carry_in, input logic sub);
    return (sub == MODE_SUB) ? ~carry_in : carry_in;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One C-bit chunk of the pipelined adder: adds two chunks plus a carry and
// exposes both the carry out of the chunk MSB and the carry into it, so the
// final chunk can produce the signed-overflow flag.
module adder_stage #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [C:0] total_s;

  // Chunk addition; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};
    sum     = total_s[C-1:0];
    cout    = total_s[C];
    msb_cin = a[C-1] ^ b[C-1] ^ total_s[C-1];
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor. Stage k adds chunk k of the
// operands, registering the chunk carry plus the still-unused upper operand
// chunks for the next stage. All stages advance together whenever the
// output register is free or being consumed, so a stall freezes the whole
// pipeline and bubbles travel with valid=0.
module pipelined_add_sub
  import lab_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow_indicator,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int C = WIDTH / STAGES;

  logic             advance_s;

  // Registered state of every stage, gathered so stage k can read stage k-1.
  logic [WIDTH-1:0] a_pipe_s     [STAGES];
  logic [WIDTH-1:0] b_pipe_s     [STAGES];
  logic [WIDTH-1:0] sum_pipe_s   [STAGES];
  logic             carry_pipe_s [STAGES];
  logic             ovf_pipe_s   [STAGES];
  logic             valid_pipe_s [STAGES];

  assign out_valid          = valid_pipe_s[STAGES-1];
  assign sum                = sum_pipe_s[STAGES-1];
  assign carry_out          = carry_pipe_s[STAGES-1];
  assign overflow_indicator = ovf_pipe_s[STAGES-1];

  assign in_ready  = !out_valid || out_ready;
  assign advance_s = in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : stage_g
    logic [WIDTH-1:0] a_in_s, b_in_s, sum_in_s;
    logic             carry_in_s, valid_in_s;
    logic [C-1:0]     chunk_sum_s;
    logic             chunk_cout_s, chunk_msb_cin_s;

    logic [WIDTH-1:0] a_d, a_q, b_d, b_q, sum_d, sum_q;
    logic             carry_d, carry_q, ovf_d, ovf_q, valid_d, valid_q;

    if (k == 0) begin : src_g
      // First stage takes the ports; subtract is folded into an inverted B
      // and carry so later stages never need to know the mode.
      always_comb begin
        a_in_s     = a;
        b_in_s     = (sub == MODE_SUB) ? ~b : b;
        carry_in_s = eff_carry_in(carry_in, sub);
        sum_in_s   = {WIDTH{1'b0}};
        valid_in_s = in_valid;
      end
    end else begin : src_g
      // Later stages continue the operation held by the previous stage.
      always_comb begin
        a_in_s     = a_pipe_s[k-1];
        b_in_s     = b_pipe_s[k-1];
        carry_in_s = carry_pipe_s[k-1];
        sum_in_s   = sum_pipe_s[k-1];
        valid_in_s = valid_pipe_s[k-1];
      end
    end

    adder_stage #(
      .C (C)
    ) u_adder_stage (
      .a       (a_in_s[k*C +: C]),
      .b       (b_in_s[k*C +: C]),
      .cin     (carry_in_s),
      .sum     (chunk_sum_s),
      .cout    (chunk_cout_s),
      .msb_cin (chunk_msb_cin_s)
    );

    // Next-state of this stage: load the new chunk result on advance, else hold.
    always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      if (advance_s) begin
        a_d                = a_in_s;
        b_d                = b_in_s;
        sum_d              = sum_in_s;
        sum_d[k*C +: C]    = chunk_sum_s;
        carry_d            = chunk_cout_s;
        ovf_d              = chunk_msb_cin_s ^ chunk_cout_s;
        valid_d            = valid_in_s;
      end else begin
        valid_d = valid_q;
      end
    end

    // Stage registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q     <= {WIDTH{1'b0}};
        b_q     <= {WIDTH{1'b0}};
        sum_q   <= {WIDTH{1'b0}};
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        valid_q <= valid_d;
      end
    end

    assign a_pipe_s[k]     = a_q;
    assign b_pipe_s[k]     = b_q;
    assign sum_pipe_s[k]   = sum_q;
    assign carry_pipe_s[k] = carry_q;
    assign ovf_pipe_s[k]   = ovf_q;
    assign valid_pipe_s[k] = valid_q;
  end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (≥2).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-high reset.
REQ-005 Port a  input  WIDTH  is operand A.
REQ-006 Port b  input  WIDTH  is operand B.
REQ-007 Port carry_in  input  1  is carry in for add, borrow in for subtract.
REQ-008 Port sub  input  1  selects the mode: 0 add, 1 subtract.
REQ-009 Port in_valid  input  1  marks a, b, carry_in and sub as valid.
REQ-010 Port in_ready  output  1  means the block accepts an operation this cycle.
REQ-011 Port sum  output  WIDTH  is the result.
REQ-012 Port carry_out  output  1  is the raw carry out of the MSB.
REQ-013 Port overflow_indicator  output  1  flags two's-complement signed overflow.
REQ-014 Port out_valid  output  1  marks the result outputs as valid.
REQ-015 Port out_ready  input  1  means the consumer accepts the result this cycle.

Function
REQ-016 An operation SHALL be accepted when in_valid && in_ready at a rising clk edge.
REQ-017 Add: {carry_out,sum} SHALL equal a + b + carry_in, computed modulo 2^(WIDTH+1).
REQ-018 Subtract: {carry_out,sum} SHALL equal a + ~b + ~carry_in, so sum = a − b − carry_in mod 2^WIDTH, and carry_out=1 means no borrow.
REQ-019 overflow_indicator SHALL equal the carry into the MSB XOR the carry out of the MSB, using the effective (possibly inverted) B.
REQ-020 Stage k (0..STAGES−1) SHALL compute chunk k, bits [(k+1)·C−1 : k·C] with C=WIDTH/STAGES; the carry SHALL be registered between stages and the upper operand chunks skewed through delay registers.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there is no stall.
REQ-022 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-023 in_ready SHALL equal !out_valid || out_ready; when it is 0, every stage SHALL hold.
REQ-024 The pipeline SHALL advance on in_ready=1 even when in_valid=0, inserting a bubble that carries valid=0.
REQ-025 sum, carry_out and overflow_indicator SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Operations SHALL emerge in acceptance order with no loss or duplication.
REQ-027 sub and carry_in SHALL be sampled at acceptance and travel with the operation, so mixed-mode back-to-back operations are independent.
REQ-028 STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 Asserting reset SHALL immediately clear out_valid, every stage valid bit, sum, carry_out, overflow_indicator and all skew/carry registers to 0.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Operations in flight when reset asserts SHALL be discarded and produce no out_valid after reset.
REQ-032 The first acceptance SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-033 Default WIDTH and STAGES, and the mode encodings (MODE_ADD=0, MODE_SUB=1), SHALL live in the shared package lab_adder_pkg.
REQ-034 One sub-module, adder_stage (a parametrised C-bit ripple adder with carry in/out and MSB carry-in tap), SHALL be instantiated STAGES times via generate.
REQ-035 Target RTL size SHALL be 120–400 lines across both modules.

Verification (WIDTH=8, STAGES=2 unless noted)
REQ-036 Exhaustive sweep: all a, b in 0..255 and carry_in in {0,1}, sub=0, streamed one per cycle with out_ready=1 -> each {carry_out,sum} = a+b+carry_in, returned in order, 2 cycles after acceptance.
REQ-037 Overflow: add a=0x7F, b=0x01, cin=0 -> sum=0x80, carry_out=0, overflow=1; sub a=0x80, b=0x01, cin=0 -> sum=0x7F, carry_out=1, overflow=1.
REQ-038 Borrow: sub a=0x00, b=0x01, cin=0 -> sum=0xFF, carry_out=0, overflow=0; sub a=5, b=3, cin=1 -> sum=0x01, carry_out=1.
REQ-039 Backpressure: stream 4 operations, hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0, outputs held, all 4 results delivered in order with none lost.
REQ-040 Reset mid-flight: accept 2 operations, assert reset the next cycle -> all outputs 0 immediately, no out_valid afterwards, in_ready=1.
REQ-041 Parameter sweep: repeat REQ-036 randomised (10k vectors, mixed sub) at WIDTH=16/STAGES=4 and WIDTH=8/STAGES=1 -> zero mismatches, latency equal to STAGES.
